// File: rtl/collision_ctl_if.sv
// Bundle of the signals between collision_ctl and its neighbours: the
// frame/player inputs, the obstacle table read port and the game controller
// link. The slave modport is the collision controller's view; the master
// modport is the surrounding logic (or a bench) that drives it.
// Handshake: there is no valid/ready pair. frame_tick is a one-cycle request,
// obst_x/obst_y/obst_active answer obst_addr exactly one cycle later,
// collision is a one-cycle pulse, and busy stays high while a scan is in flight.
interface collision_ctl_if #(
    parameter int NUM_OBST = 8,
    parameter int COORD_W  = 11
);
    localparam int IDX_W = $clog2(NUM_OBST);

    logic               frame_tick;
    logic [COORD_W-1:0] player_x;
    logic [COORD_W-1:0] player_y;
    logic [IDX_W-1:0]   obst_addr;
    logic [COORD_W-1:0] obst_x;
    logic [COORD_W-1:0] obst_y;
    logic               obst_active;
    logic [2:0]         game_state;
    logic               game_en;
    logic               game_reset;
    logic               collision;
    logic [IDX_W-1:0]   hit_idx;
    logic               busy;
    logic [1:0]         dbg_state;

    modport master (
        output frame_tick, player_x, player_y, obst_x, obst_y, obst_active,
               game_state, game_en, game_reset,
        input  obst_addr, collision, hit_idx, busy, dbg_state
    );

    modport slave (
        input  frame_tick, player_x, player_y, obst_x, obst_y, obst_active,
               game_state, game_en, game_reset,
        output obst_addr, collision, hit_idx, busy, dbg_state
    );
endinterface

// File: rtl/collision_ctl.sv
// Per-frame collision detector. On frame_tick it walks the obstacle table
// through a one-cycle-latency read port, tests each active entry's box against
// the latched player box, and in a final DECIDE cycle emits a one-cycle
// collision pulse on a rising overlap while the game is playing.
module collision_ctl #(
    parameter int         NUM_OBST     = 8,
    parameter int         COORD_W      = 11,
    parameter int         PLAYER_W     = 32,
    parameter int         PLAYER_H     = 32,
    parameter int         OBST_W       = 32,
    parameter int         OBST_H       = 32,
    parameter logic [2:0] PLAYING_CODE = 3'b010
) (
    input  logic              clk,
    input  logic              hard_reset_n,
    collision_ctl_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_OBST);
    // One extra bit so box edge sums never wrap.
    localparam int SW    = COORD_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        LAST   = 2'd2,
        DECIDE = 2'd3
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   first_q;
    logic [IDX_W-1:0]   hit_idx_q;
    logic               found_q;
    logic               overlap_prev_q;
    logic               collision_q;
    logic               busy_q;
    logic [COORD_W-1:0] px_q;
    logic [COORD_W-1:0] py_q;

    logic               cmp_valid_d;
    logic [IDX_W-1:0]   cmp_idx_d;
    logic               entry_hit_d;
    logic [SW-1:0]      px_e, py_e, ox_e, oy_e;

    assign px_e = {1'b0, px_q};
    assign py_e = {1'b0, py_q};
    assign ox_e = {1'b0, bus.obst_x};
    assign oy_e = {1'b0, bus.obst_y};

    // Read data on the bus belongs to the address issued one cycle earlier;
    // in LAST that is always the final table entry.
    assign cmp_valid_d = ((state_q == SCAN) && (idx_q != '0)) || (state_q == LAST);
    assign cmp_idx_d   = (state_q == LAST) ? LAST_IDX : idx_q - IDX_W'(1);

    // Strict inequalities: boxes that only share an edge do not overlap.
    assign entry_hit_d = bus.obst_active
                      && (px_e < ox_e + SW'(OBST_W))
                      && (ox_e < px_e + SW'(PLAYER_W))
                      && (py_e < oy_e + SW'(OBST_H))
                      && (oy_e < py_e + SW'(PLAYER_H));

    assign bus.obst_addr = idx_q;
    assign bus.collision = collision_q;
    assign bus.hit_idx   = hit_idx_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;

    // Scan sequencer, hit accumulator and registered outputs.
    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            first_q        <= '0;
            hit_idx_q      <= '0;
            found_q        <= 1'b0;
            overlap_prev_q <= 1'b0;
            collision_q    <= 1'b0;
            busy_q         <= 1'b0;
            px_q           <= '0;
            py_q           <= '0;
        end else begin
            collision_q <= 1'b0;
            if (bus.game_reset) begin
                // Abort wins over everything, including a same-cycle frame_tick.
                state_q        <= IDLE;
                idx_q          <= '0;
                hit_idx_q      <= '0;
                found_q        <= 1'b0;
                overlap_prev_q <= 1'b0;
                busy_q         <= 1'b0;
            end else begin
                // Scanning is in address order, so the first hit is the lowest index.
                if (cmp_valid_d && entry_hit_d && !found_q) begin
                    found_q <= 1'b1;
                    first_q <= cmp_idx_d;
                end
                case (state_q)
                    IDLE: begin
                        if (bus.frame_tick) begin
                            px_q    <= bus.player_x;
                            py_q    <= bus.player_y;
                            idx_q   <= '0;
                            found_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= LAST;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                    LAST: begin
                        idx_q   <= '0;
                        state_q <= DECIDE;
                    end
                    DECIDE: begin
                        // Pulse only on a rising overlap; the history updates even when gated.
                        collision_q    <= found_q && !overlap_prev_q && bus.game_en
                                       && (bus.game_state == PLAYING_CODE);
                        overlap_prev_q <= found_q;
                        if (found_q) begin
                            hit_idx_q <= first_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_collision_ctl.sv
// Bench for collision_ctl: a registered obstacle table model answers the read
// port, a vector table drives whole frames, and hand-written sequences cover
// abort, same-cycle reset/tick and frame_tick while busy.
module tb_collision_ctl;
    localparam int N  = 8;
    localparam int CW = 11;

    typedef struct {
        logic [CW-1:0] px;
        logic [CW-1:0] py;
        logic [2:0]    gs;
        logic          ge;
        int            n;
        int            ia;
        logic [CW-1:0] ax;
        logic [CW-1:0] ay;
        int            ib;
        logic [CW-1:0] bx;
        logic [CW-1:0] by;
        logic          exp_pulse;
        logic [2:0]    exp_hit;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [4:0]    exp_q[$];
    vec_t          vecs[$];
    logic [CW-1:0] tab_x[N];
    logic [CW-1:0] tab_y[N];
    logic          tab_act[N];

    collision_ctl_if #(.NUM_OBST(N), .COORD_W(CW)) bus();

    collision_ctl #(.NUM_OBST(N), .COORD_W(CW)) dut (
        .clk         (clk),
        .hard_reset_n(rst_n),
        .bus         (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Obstacle table with one cycle of read latency.
    always @(posedge clk) begin
        bus.obst_x      <= tab_x[bus.obst_addr];
        bus.obst_y      <= tab_y[bus.obst_addr];
        bus.obst_active <= tab_act[bus.obst_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int px, input int py, input logic [2:0] gs, input logic ge,
                                input int n, input int ia, input int ax, input int ay,
                                input int ib, input int bx, input int by,
                                input logic ep, input int eh);
        vec_t v;
        v.px = CW'(px); v.py = CW'(py); v.gs = gs; v.ge = ge;
        v.n = n; v.ia = ia; v.ax = CW'(ax); v.ay = CW'(ay);
        v.ib = ib; v.bx = CW'(bx); v.by = CW'(by);
        v.exp_pulse = ep; v.exp_hit = 3'(eh);
        return v;
    endfunction

    task automatic clear_table();
        for (int i = 0; i < N; i++) begin
            tab_x[i] = '0; tab_y[i] = '0; tab_act[i] = 1'b0;
        end
    endtask

    // Runs one frame from frame_tick. abort_at/tick_at (0 = unused) inject a
    // game_reset or an extra frame_tick (plus a player move) in that cycle.
    task automatic run_frame(input logic exp_pulse, input logic [2:0] exp_hit,
                             input int abort_at, input int tick_at, input string name);
        int         pulses;
        int         pulse_at;
        int         sched_bad;
        int         end_k;
        logic       good;
        logic       extra;
        logic [2:0] hit_seen;
        logic [4:0] obs;
        int         exp_addr;
        exp_q.push_back({exp_pulse, 1'b0, exp_hit});
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        pulses = 0; pulse_at = 0; sched_bad = 0; hit_seen = '0;
        end_k = (abort_at > 0) ? abort_at : N + 2;
        for (int k = 1; k <= N + 6; k++) begin
            bus.game_reset = 1'b0;
            bus.frame_tick = 1'b0;
            if (bus.collision) begin
                pulses++;
                pulse_at = k;
            end
            if (bus.busy !== 1'(k <= end_k)) sched_bad++;
            exp_addr = -1;
            if (abort_at > 0 && k > abort_at) exp_addr = 0;
            else if (k <= N)                  exp_addr = k - 1;
            else if (k == N + 1)              exp_addr = N - 1;
            else if (k >= N + 3)              exp_addr = 0;
            if (exp_addr >= 0 && 32'(bus.obst_addr) != exp_addr) sched_bad++;
            if (k == N + 3) hit_seen = bus.hit_idx;
            if (k == abort_at) bus.game_reset = 1'b1;
            if (k == tick_at) begin
                bus.frame_tick = 1'b1;
                bus.player_x   = CW'(1000);
                bus.player_y   = CW'(1000);
            end
            @(posedge clk); #1;
        end
        good  = (pulses == 1) && (pulse_at == N + 3);
        extra = (pulses != (good ? 1 : 0));
        obs   = {good, extra, hit_seen};
        check({name, "_sched"}, 32'(sched_bad), 32'd0);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty actual=%0h", name, obs);
        end else begin
            check(name, 32'(obs), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic apply_vec(input vec_t v);
        clear_table();
        if (v.n >= 1) begin tab_x[v.ia] = v.ax; tab_y[v.ia] = v.ay; tab_act[v.ia] = 1'b1; end
        if (v.n >= 2) begin tab_x[v.ib] = v.bx; tab_y[v.ib] = v.by; tab_act[v.ib] = 1'b1; end
        bus.player_x   = v.px;
        bus.player_y   = v.py;
        bus.game_state = v.gs;
        bus.game_en    = v.ge;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_table();
        bus.frame_tick  = 1'b0;
        bus.player_x    = '0;
        bus.player_y    = '0;
        bus.game_state  = 3'b010;
        bus.game_en     = 1'b1;
        bus.game_reset  = 1'b0;
        bus.obst_x      = '0;
        bus.obst_y      = '0;
        bus.obst_active = 1'b0;

        // Vector table: player/game inputs, table contents, expected pulse and hit_idx.
        //              px    py    gs      ge  n  ia  ax    ay   ib bx   by   pulse hit
        vecs.push_back(mk(110,  210,  3'b010, 1, 1, 5, 100,  200, 0, 0,   0,   1, 5)); // single hit
        vecs.push_back(mk(110,  210,  3'b010, 1, 1, 5, 100,  200, 0, 0,   0,   0, 5)); // persists
        vecs.push_back(mk(110,  210,  3'b010, 1, 1, 5, 100,  200, 0, 0,   0,   0, 5)); // persists
        vecs.push_back(mk(400,  400,  3'b010, 1, 1, 5, 100,  200, 0, 0,   0,   0, 5)); // clear
        vecs.push_back(mk(110,  210,  3'b010, 1, 1, 5, 100,  200, 0, 0,   0,   1, 5)); // re-armed
        vecs.push_back(mk(68,   100,  3'b010, 1, 1, 0, 100,  100, 0, 0,   0,   0, 5)); // touching
        vecs.push_back(mk(69,   100,  3'b010, 1, 1, 0, 100,  100, 0, 0,   0,   1, 0)); // one pixel in
        vecs.push_back(mk(69,   100,  3'b010, 1, 0, 0, 100,  100, 0, 0,   0,   0, 0)); // inactive
        vecs.push_back(mk(69,   100,  3'b011, 1, 1, 0, 100,  100, 0, 0,   0,   0, 0)); // not playing
        vecs.push_back(mk(69,   100,  3'b010, 1, 1, 0, 100,  100, 0, 0,   0,   0, 0)); // still overlapping
        vecs.push_back(mk(400,  400,  3'b010, 1, 1, 0, 100,  100, 0, 0,   0,   0, 0)); // clear
        vecs.push_back(mk(69,   100,  3'b010, 1, 1, 0, 100,  100, 0, 0,   0,   1, 0)); // pulse
        vecs.push_back(mk(400,  400,  3'b010, 1, 1, 0, 100,  100, 0, 0,   0,   0, 0)); // clear
        vecs.push_back(mk(69,   100,  3'b010, 0, 1, 0, 100,  100, 0, 0,   0,   0, 0)); // game_en=0
        vecs.push_back(mk(69,   100,  3'b010, 1, 1, 0, 100,  100, 0, 0,   0,   0, 0)); // enabled, no edge
        vecs.push_back(mk(400,  400,  3'b010, 1, 2, 2, 300,  300, 6, 300, 300, 0, 0)); // clear
        vecs.push_back(mk(310,  310,  3'b010, 1, 2, 2, 300,  300, 6, 300, 300, 1, 2)); // two hits
        vecs.push_back(mk(1000, 1000, 3'b010, 1, 1, 3, 2040, 500, 0, 0,   0,   0, 2)); // clear
        vecs.push_back(mk(2047, 500,  3'b010, 1, 1, 3, 2040, 500, 0, 0,   0,   1, 3)); // x limit

        rst_n = 1'b0;
        #23;
        check("reset_collision", 32'(bus.collision), 32'd0);
        check("reset_hit_idx",   32'(bus.hit_idx),   32'd0);
        check("reset_busy",      32'(bus.busy),      32'd0);
        check("reset_addr",      32'(bus.obst_addr), 32'd0);
        check("reset_state",     32'(bus.dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i]);
            run_frame(vecs[i].exp_pulse, vecs[i].exp_hit, 0, 0, $sformatf("vec%0d", i));
        end

        // Abort in scan cycle 3: no pulse, hit_idx cleared, history cleared.
        run_frame(1'b0, 3'd0, 3, 0, "abort");
        run_frame(1'b1, 3'd3, 0, 0, "after_abort");
        bus.player_x = CW'(1000);
        bus.player_y = CW'(1000);
        run_frame(1'b0, 3'd3, 0, 0, "clear_again");
        // Extra frame_tick and a player move mid-scan must both be ignored.
        bus.player_x = CW'(2047);
        bus.player_y = CW'(500);
        run_frame(1'b1, 3'd3, 0, 4, "tick_while_busy");

        // game_reset in IDLE clears hit_idx.
        @(negedge clk);
        bus.game_reset = 1'b1;
        @(posedge clk); #1;
        bus.game_reset = 1'b0;
        check("idle_reset_hit", 32'(bus.hit_idx), 32'd0);

        // game_reset beats a same-cycle frame_tick.
        @(negedge clk);
        bus.game_reset = 1'b1;
        bus.frame_tick = 1'b1;
        @(posedge clk); #1;
        bus.game_reset = 1'b0;
        bus.frame_tick = 1'b0;
        check("reset_vs_tick_busy",  32'(bus.busy),      32'd0);
        check("reset_vs_tick_state", 32'(bus.dbg_state), 32'd0);
        repeat (N + 4) @(posedge clk);
        #1;
        check("reset_vs_tick_nopulse", 32'(bus.collision), 32'd0);
        check("scoreboard_drained",    32'(exp_q.size()),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
